// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - RV32I instruction assembler: range-checks an immediate and packs it into an instruction word.
// Optional IMM_ENC_STATS_EN adds saturating handshake/error counters (stat_count, stat_err).
module imm_encoder #(
    parameter int STAT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_count,
    output logic [STAT_W-1:0] stat_err
`endif
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic        r_s1_valid;
    logic [2:0]  r_s1_fmt;
    logic [6:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_funct3;
    logic [6:0]  r_s1_funct7;
    logic [31:0] r_s1_imm;
    logic        r_s1_err;

    logic        r_s2_valid;
    logic [31:0] r_s2_instr;
    logic        r_s2_err;

    logic        w_s1_load;
    logic        w_s2_load;
    logic        w_range_err;
    logic [31:0] w_instr;

    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_s1_load = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;

    // Representability: the bits above the format's sign bit must all match it.
    always_comb begin
        w_range_err = 1'b0;
        case (in_fmt)
            FMT_R:        w_range_err = 1'b0;
            FMT_I, FMT_S: w_range_err = (in_imm[31:11] != {21{in_imm[11]}});
            FMT_B:        w_range_err = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            FMT_U:        w_range_err = (in_imm[11:0] != 12'd0);
            FMT_J:        w_range_err = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            default:      w_range_err = 1'b1;
        endcase
    end

    always_comb begin
        w_instr = 32'h0000_0013;
        case (r_s1_fmt)
            FMT_R: w_instr = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_I: w_instr = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_S: w_instr = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                              r_s1_imm[4:0], r_s1_opcode};
            FMT_B: w_instr = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                              r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
            FMT_U: w_instr = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
            FMT_J: w_instr = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                              r_s1_rd, r_s1_opcode};
            default: w_instr = 32'h0000_0013;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= 3'd0;
            r_s1_opcode <= 7'd0;
            r_s1_rd     <= 5'd0;
            r_s1_rs1    <= 5'd0;
            r_s1_rs2    <= 5'd0;
            r_s1_funct3 <= 3'd0;
            r_s1_funct7 <= 7'd0;
            r_s1_imm    <= 32'd0;
            r_s1_err    <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid  <= 1'b1;
            r_s1_fmt    <= in_fmt;
            r_s1_opcode <= in_opcode;
            r_s1_rd     <= in_rd;
            r_s1_rs1    <= in_rs1;
            r_s1_rs2    <= in_rs2;
            r_s1_funct3 <= in_funct3;
            r_s1_funct7 <= in_funct7;
            r_s1_imm    <= in_imm;
            r_s1_err    <= w_range_err;
        end else if (w_s2_load) begin
            r_s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= 32'd0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_instr <= w_instr;
            r_s2_err   <= r_s1_err;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

`ifdef IMM_ENC_STATS_EN
    logic [STAT_W-1:0] r_stat_count;
    logic [STAT_W-1:0] r_stat_err;
    logic              w_out_fire;

    assign w_out_fire = r_s2_valid && out_ready;
    assign stat_count = r_stat_count;
    assign stat_err   = r_stat_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_count <= '0;
            r_stat_err   <= '0;
        end else if (w_out_fire) begin
            if (r_stat_count != '1) r_stat_count <= r_stat_count + 1'b1;
            if (r_s2_err && (r_stat_err != '1)) r_stat_err <= r_stat_err + 1'b1;
        end
    end
`else
    logic [STAT_W-1:0] w_unused_stat;
    assign w_unused_stat = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed-vector bench for imm_encoder with a scoreboard model.
module tb_imm_encoder;

    localparam int STAT_W = 16;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
`ifdef IMM_ENC_STATS_EN
    logic [STAT_W-1:0] stat_count;
    logic [STAT_W-1:0] stat_err;
`endif

    int n_vec = 0;
    int n_fail = 0;
    int n_hs = 0;
    int n_hs_err = 0;
    logic [32:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_out = '0;

    always #5 clk = ~clk;

    imm_encoder #(.STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err)
`ifdef IMM_ENC_STATS_EN
        , .stat_count(stat_count), .stat_err(stat_err)
`endif
    );

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected {err, instr} from signed ranges and bit positions, built with shifts and adds.
    function automatic logic [32:0] model(input vec_t v);
        longint      s;
        logic [31:0] u;
        logic [31:0] ins;
        logic        err;
        s   = longint'($signed(v.imm));
        u   = v.imm;
        ins = 32'(v.op);
        err = 1'b0;
        case (v.fmt)
            3'd0: ins += (32'(v.rd) << 7) + (32'(v.f3) << 12) + (32'(v.rs1) << 15)
                       + (32'(v.rs2) << 20) + (32'(v.f7) << 25);
            3'd1: begin
                err = (s < -2048) || (s > 2047);
                ins += (32'(v.rd) << 7) + (32'(v.f3) << 12) + (32'(v.rs1) << 15)
                     + ((u & 32'hFFF) << 20);
            end
            3'd2: begin
                err = (s < -2048) || (s > 2047);
                ins += ((u & 32'h1F) << 7) + (32'(v.f3) << 12) + (32'(v.rs1) << 15)
                     + (32'(v.rs2) << 20) + (((u >> 5) & 32'h7F) << 25);
            end
            3'd3: begin
                err = (s < -4096) || (s > 4095) || ((u % 2) != 0);
                ins += (((u >> 11) & 32'h1) << 7) + (((u >> 1) & 32'hF) << 8)
                     + (32'(v.f3) << 12) + (32'(v.rs1) << 15) + (32'(v.rs2) << 20)
                     + (((u >> 5) & 32'h3F) << 25) + (((u >> 12) & 32'h1) << 31);
            end
            3'd4: begin
                err = (u % 4096) != 0;
                ins += (32'(v.rd) << 7) + (u & 32'hFFFF_F000);
            end
            3'd5: begin
                err = (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1) || ((u % 2) != 0);
                ins += (32'(v.rd) << 7) + (((u >> 12) & 32'hFF) << 12)
                     + (((u >> 11) & 32'h1) << 20) + (((u >> 1) & 32'h3FF) << 21)
                     + (((u >> 20) & 32'h1) << 31);
            end
            default: begin
                ins = 32'h0000_0013;
                err = 1'b1;
            end
        endcase
        return {err, ins};
    endfunction

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm;
        return v;
    endfunction

    // Scoreboard: accepts and output handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_stable", {out_err, out_instr}, prev_out);
            if (in_valid && in_ready)
                exp_q.push_back(model(mk(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                         in_funct3, in_funct7, in_imm)));
            if (out_valid && out_ready) begin
                n_hs++;
                if (out_err) n_hs_err++;
                if (exp_q.size() == 0)
                    check("spurious_out", 33'(exp_q.size()), 33'd1);
                else
                    check("stream_out", {out_err, out_instr}, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_err, out_instr};
        end
    end

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
        in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    endtask

    task automatic send(input vec_t v);
        int cnt;
        cnt = 0;
        drive(v);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) check("send_timeout", 33'(in_ready), 33'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Pipeline must be empty and out_ready high on entry.
    task automatic send_chk(input string name, input vec_t v, input logic [32:0] lit);
        check({name, "_model"}, model(v), lit);
        send(v);
        check({name, "_lat1"}, 33'(out_valid), 33'd0);
        @(posedge clk);
        #1;
        check({name, "_lat2"}, 33'(out_valid), 33'd1);
        check(name, {out_err, out_instr}, lit);
    endtask

    vec_t v_i, v_s, v_b, v_u, v_j, v_r;
    vec_t tbl[8];
    int   hs0;

    initial begin
        v_i = mk(3'd1, 7'h03, 5'd7, 5'd2, 5'd0,  3'd2, 7'h00, 32'hFFFF_FFFF);
        v_s = mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd15, 3'd2, 7'h00, 32'h0000_0006);
        v_b = mk(3'd3, 7'h63, 5'd0, 5'd2, 5'd5,  3'd2, 7'h00, 32'hFFFF_FFFC);
        v_u = mk(3'd4, 7'h37, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'h1234_5000);
        v_j = mk(3'd5, 7'h6F, 5'd2, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFF0_0FFE);
        v_r = mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3,  3'd0, 7'h20, 32'hDEAD_BEEF);

        #1;
        check("rst_out_valid", 33'(out_valid), 33'd0);
        check("rst_in_ready", 33'(in_ready), 33'd1);
        check("rst_out", {out_err, out_instr}, 33'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send_chk("I",  v_i, {1'b0, 32'hFFF1_2383});
        send_chk("S",  v_s, {1'b0, 32'h00F1_2323});
        send_chk("B",  v_b, {1'b0, 32'hFE51_2EE3});
        send_chk("U",  v_u, {1'b0, 32'h1234_5037});
        send_chk("J",  v_j, {1'b0, 32'hFFF0_016F});
        send_chk("R",  v_r, {1'b0, 32'h4031_00B3});
        send_chk("I_err",  mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800), {1'b1, 32'h8000_0013});
        send_chk("I_min",  mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800), {1'b0, 32'h8000_0013});
        send_chk("B_err",  mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005), {1'b1, 32'h0000_0263});
        send_chk("U_err",  mk(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001), {1'b1, 32'h1234_5037});
        send_chk("fmt6",   mk(3'd6, 7'h33, 5'd9, 5'd1, 5'd1, 3'd1, 7'h01, 32'h0000_0000), {1'b1, 32'h0000_0013});
        send_chk("fmt7",   mk(3'd7, 7'h6F, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0004), {1'b1, 32'h0000_0013});
        @(posedge clk);
        #1;

        // Backpressure: two accepted, third held off, then all three drain in order.
        hs0 = n_hs;
        out_ready = 1'b0;
        send(v_i);
        send(v_s);
        drive(v_b);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 33'(in_ready), 33'd0);
            check("bp_hold", {out_err, out_instr}, {1'b0, 32'hFFF1_2383});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept3", 33'(in_ready), 33'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drain", 33'(exp_q.size()), 33'd0);
        check("bp_count", 33'(n_hs - hs0), 33'd3);

        // Back-to-back stream with a fixed out_ready pattern.
        tbl[0] = v_r; tbl[1] = v_j; tbl[2] = v_u; tbl[3] = v_b;
        tbl[4] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000);
        tbl[5] = mk(3'd2, 7'h23, 5'd0, 5'd8, 5'd9, 3'd1, 7'h00, 32'hFFFF_F800);
        tbl[6] = mk(3'd3, 7'h63, 5'd0, 5'd4, 5'd6, 3'd5, 7'h00, 32'h0000_0FFE);
        tbl[7] = v_s;
        hs0 = n_hs;
        fork
            begin
                for (int k = 0; k < 8; k++) send(tbl[k]);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1 out_ready = (c % 3) != 2;
                end
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("stream_drain", 33'(exp_q.size()), 33'd0);
        check("stream_count", 33'(n_hs - hs0), 33'd8);

`ifdef IMM_ENC_STATS_EN
        check("stat_count", 33'(stat_count), 33'(n_hs));
        check("stat_err", 33'(stat_err), 33'(n_hs_err));
`endif

        // Async reset with both stages full.
        out_ready = 1'b0;
        send(v_u);
        send(v_j);
        check("full_in_ready", 33'(in_ready), 33'd0);
        #1 rst = 1'b1;
        exp_q.delete();
        n_hs = 0;
        n_hs_err = 0;
        #1;
        check("arst_out_valid", 33'(out_valid), 33'd0);
        check("arst_in_ready", 33'(in_ready), 33'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_chk("post_rst", v_i, {1'b0, 32'hFFF1_2383});
        @(posedge clk);
        #1;
        check("final_drain", 33'(exp_q.size()), 33'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
